serial_tx_fifo: RTL and testbench

//  Parametrised SPI-like serial transmitter with an input word FIFO. Upstream pushes

---
 rtl/serial_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_serial_tx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// Serial transmitter with a WIDTH-bit word FIFO. A word pushed into an empty, idle block goes out starting at the next sclk negedge.
// load_ready drops while the FIFO is full. The chip-select frame lasts WIDTH clocks and is followed by at least GAP low clocks.
module serial_tx_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         load_data,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         load_ready,
  output logic                         data_enable,
  output logic                         sdo,
  output logic                         tran_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WIDTH+1);
  localparam int GW = $clog2(GAP+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRAN = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_sh;
  logic [WIDTH-1:0] sr_sh;
  logic             first_bit;
  logic             next_bit;

  assign load_ready = (fifo_count != CW'(DEPTH));
  assign push       = load_data && load_ready;
  assign pop        = (state == S_IDLE) && (fifo_count != '0);
  assign busy       = (state != S_IDLE) || (fifo_count != '0);
  assign head       = mem[rd_ptr];

  // Bit order only changes which end of the word leaves first and the shift direction.
  always_comb begin
    first_bit = head[0];
    head_sh   = {1'b0, head[WIDTH-1:1]};
    next_bit  = shift_reg[0];
    sr_sh     = {1'b0, shift_reg[WIDTH-1:1]};
    if (MSB_FIRST != 0) begin
      first_bit = head[WIDTH-1];
      head_sh   = {head[WIDTH-2:0], 1'b0};
      next_bit  = shift_reg[WIDTH-1];
      sr_sh     = {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(negedge sclk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      sdo         <= 1'b0;
      data_enable <= 1'b0;
      tran_done   <= 1'b0;
    end else begin
      tran_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift_reg   <= head_sh;
            sdo         <= first_bit;
            data_enable <= 1'b1;
            bit_cnt     <= BW'(1);
            state       <= S_TRAN;
          end else begin
            sdo         <= 1'b0;
            data_enable <= 1'b0;
          end
        end
        S_TRAN: begin
          // bit_cnt already equals WIDTH once the last bit is on sdo; this edge ends the frame.
          if (bit_cnt == BW'(WIDTH)) begin
            data_enable <= 1'b0;
            sdo         <= 1'b0;
            tran_done   <= 1'b1;
            gap_cnt     <= GW'(1);
            bit_cnt     <= '0;
            state       <= (GAP > 1) ? S_GAP : S_IDLE;
          end else begin
            sdo       <= next_bit;
            shift_reg <= sr_sh;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          data_enable <= 1'b0;
          sdo         <= 1'b0;
          if (gap_cnt == GW'(GAP-1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          data_enable <= 1'b0;
          sdo         <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: an MSB-first GAP=2 instance and an LSB-first GAP=1 instance, both WIDTH=8 DEPTH=4.
module tb_serial_tx_fifo;

  logic       sclk  = 1'b0;
  logic       rst_n = 1'b1;
  logic       ld     [2];
  logic [7:0] din    [2];
  logic       rdy_w  [2];
  logic       de_w   [2];
  logic       sdo_w  [2];
  logic       td_w   [2];
  logic       busy_w [2];
  logic [2:0] cnt_w  [2];

  int vectors     = 0;
  int miscompares = 0;
  logic abort_ok  = 1'b0;

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  int         gaps0 [$];
  int         gaps1 [$];
  logic [7:0] rx     [2];
  int         bits   [2] = '{0, 0};
  int         lowrun [2] = '{0, 0};
  int         td_cnt [2] = '{0, 0};
  int         rises  [2] = '{0, 0};
  logic       prev   [2] = '{1'b0, 1'b0};

  always #5 sclk = ~sclk;

  serial_tx_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .GAP(2)) dut_m (
    .sclk(sclk), .rst_n(rst_n), .load_data(ld[0]), .data_in(din[0]),
    .load_ready(rdy_w[0]), .data_enable(de_w[0]), .sdo(sdo_w[0]),
    .tran_done(td_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0])
  );

  serial_tx_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .GAP(1)) dut_l (
    .sclk(sclk), .rst_n(rst_n), .load_data(ld[1]), .data_in(din[1]),
    .load_ready(rdy_w[1]), .data_enable(de_w[1]), .sdo(sdo_w[1]),
    .tran_done(td_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] w, input bit accept);
    ld[k]  = 1'b1;
    din[k] = w;
    if (accept) begin
      if (k == 0) sb0.push_back(w);
      else        sb1.push_back(w);
    end
    step(1);
    ld[k] = 1'b0;
  endtask

  task automatic check_frame(input int k, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("de_k%0d_bit%0d", k, i), de_w[k], 1);
      chk($sformatf("sdo_k%0d_bit%0d", k, i), sdo_w[k], (k == 0) ? w[7-i] : w[i]);
    end
    step(1);
    chk($sformatf("de_end_k%0d", k), de_w[k], 0);
    chk($sformatf("sdo_end_k%0d", k), sdo_w[k], 0);
    chk($sformatf("done_k%0d", k), td_w[k], 1);
  endtask

  // Frame receiver and scoreboard; samples half a cycle after the active negedge.
  always @(posedge sclk) begin
    for (int k = 0; k < 2; k++) begin
      if (de_w[k] === 1'b1) begin
        if (k == 0) rx[k] = {rx[k][6:0], sdo_w[k]};
        else        rx[k] = {sdo_w[k], rx[k][7:1]};
        if (prev[k] !== 1'b1) begin
          rises[k]++;
          if (k == 0) gaps0.push_back(lowrun[k]);
          else        gaps1.push_back(lowrun[k]);
        end
        bits[k]++;
        lowrun[k] = 0;
      end else begin
        if (prev[k] === 1'b1 && !abort_ok) begin
          chk($sformatf("frame_len_k%0d", k), bits[k], 8);
          chk($sformatf("frame_done_k%0d", k), td_w[k], 1);
          if (k == 0) begin
            if (sb0.size() > 0) chk("word_k0", rx[0], sb0.pop_front());
            else                chk("unexpected_frame_k0", 0, 1);
          end else begin
            if (sb1.size() > 0) chk("word_k1", rx[1], sb1.pop_front());
            else                chk("unexpected_frame_k1", 0, 1);
          end
        end
        bits[k] = 0;
        lowrun[k]++;
      end
      if (td_w[k] === 1'b1) td_cnt[k]++;
      prev[k] = de_w[k];
    end
  end

  initial begin
    int td0;
    int r0;
    ld[0] = 1'b0; ld[1] = 1'b0;
    din[0] = '0;  din[1] = '0;
    #1 rst_n = 1'b0;
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_de_k%0d", k), de_w[k], 0);
      chk($sformatf("rst_sdo_k%0d", k), sdo_w[k], 0);
      chk($sformatf("rst_done_k%0d", k), td_w[k], 0);
      chk($sformatf("rst_rdy_k%0d", k), rdy_w[k], 1);
      chk($sformatf("rst_cnt_k%0d", k), cnt_w[k], 0);
      chk($sformatf("rst_busy_k%0d", k), busy_w[k], 0);
    end
    @(posedge sclk);
    #2 rst_n = 1'b1;
    step(1);

    // MSB-first 0xA5 with one-edge start latency
    push(0, 8'hA5, 1);
    chk("t1_cnt_after_push", cnt_w[0], 1);
    chk("t1_de_after_push", de_w[0], 0);
    chk("t1_busy_after_push", busy_w[0], 1);
    check_frame(0, 8'hA5);
    chk("t1_busy_in_gap", busy_w[0], 1);
    step(1);
    chk("t1_done_one_clock", td_w[0], 0);
    chk("t1_busy_idle", busy_w[0], 0);

    // LSB-first frames and GAP=1 spacing
    push(1, 8'hA5, 1);
    check_frame(1, 8'hA5);
    push(1, 8'h01, 1);
    check_frame(1, 8'h01);
    step(1);
    gaps1.delete();
    push(1, 8'h3C, 1);
    push(1, 8'hC3, 1);
    step(25);
    chk("t2_gap_frames", gaps1.size(), 2);
    chk("t2_gap_len", (gaps1.size() > 1) ? gaps1[1] : 32'hFFFF, 1);
    chk("t2_sb_drained", sb1.size(), 0);
    chk("t2_busy_end", busy_w[1], 0);

    // three back-to-back frames with GAP=2
    td0 = td_cnt[0];
    gaps0.delete();
    push(0, 8'h11, 1);
    push(0, 8'h22, 1);
    push(0, 8'h33, 1);
    step(40);
    chk("t3_frames", gaps0.size(), 3);
    chk("t3_gap1", (gaps0.size() > 1) ? gaps0[1] : 32'hFFFF, 2);
    chk("t3_gap2", (gaps0.size() > 2) ? gaps0[2] : 32'hFFFF, 2);
    chk("t3_done_pulses", td_cnt[0] - td0, 3);
    chk("t3_sb_drained", sb0.size(), 0);
    chk("t3_busy_end", busy_w[0], 0);

    // overfill while the first frame runs
    td0 = td_cnt[0];
    push(0, 8'h40, 1);
    push(0, 8'h41, 1);
    push(0, 8'h42, 1);
    push(0, 8'h43, 1);
    chk("t4_cnt3", cnt_w[0], 3);
    chk("t4_rdy_cnt3", rdy_w[0], 1);
    push(0, 8'h44, 1);
    chk("t4_cnt_full", cnt_w[0], 4);
    chk("t4_rdy_full", rdy_w[0], 0);
    push(0, 8'h45, 0);
    push(0, 8'h46, 0);
    chk("t4_cnt_still_full", cnt_w[0], 4);
    chk("t4_rdy_still_low", rdy_w[0], 0);
    step(70);
    chk("t4_done_pulses", td_cnt[0] - td0, 5);
    chk("t4_sb_drained", sb0.size(), 0);
    chk("t4_busy_end", busy_w[0], 0);
    chk("t4_rdy_end", rdy_w[0], 1);

    // push coinciding with pop at DEPTH-1
    push(0, 8'h50, 1);
    push(0, 8'h51, 1);
    push(0, 8'h52, 1);
    push(0, 8'h53, 1);
    chk("t6_cnt_pre", cnt_w[0], 3);
    step(7);
    chk("t6_cnt_before_pop", cnt_w[0], 3);
    chk("t6_de_before_pop", de_w[0], 0);
    push(0, 8'h54, 1);
    chk("t6_cnt_same_edge", cnt_w[0], 3);
    chk("t6_rdy_same_edge", rdy_w[0], 1);
    chk("t6_de_started", de_w[0], 1);
    step(50);
    chk("t6_sb_drained", sb0.size(), 0);
    chk("t6_busy_end", busy_w[0], 0);

    // reset in the middle of a frame with two words queued
    td0 = td_cnt[0];
    r0  = rises[0];
    push(0, 8'h60, 1);
    push(0, 8'h61, 1);
    push(0, 8'h62, 1);
    step(1);
    chk("t5_de_mid", de_w[0], 1);
    chk("t5_cnt_mid", cnt_w[0], 2);
    abort_ok = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_de_async", de_w[0], 0);
    chk("t5_sdo_async", sdo_w[0], 0);
    chk("t5_done_async", td_w[0], 0);
    chk("t5_cnt_async", cnt_w[0], 0);
    chk("t5_rdy_async", rdy_w[0], 1);
    sb0.delete();
    step(2);
    @(posedge sclk);
    #2 rst_n = 1'b1;
    abort_ok = 1'b0;
    step(30);
    chk("t5_no_done", td_cnt[0] - td0, 0);
    chk("t5_no_new_frames", rises[0] - r0, 1);
    chk("t5_cnt_after", cnt_w[0], 0);
    chk("t5_busy_after", busy_w[0], 0);
    chk("t5_de_after", de_w[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
